// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer on the CPU data-memory bus.
// Register window (16 bytes at BASE): +0 CTRL, +4 PRESET, +8 COUNT (RO), +C reserved.
// IRQ is the masked interrupt flag and feeds a CP0 HWInt input.
module timer_dev #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic [3:0]  WE,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;      // [3] IM, [2:1] Mode, [0] Enable
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_q, irq_d;

    logic        sel;
    logic [1:0]  idx;
    logic        wr;

    // Addr is a word address, so byte-address bits [31:4] sit at Addr[29:2].
    assign sel = (Addr[29:2] == BASE[31:4]);
    assign idx = Addr[1:0];
    assign wr  = sel && (WE == 4'b1111);

    // Zero-latency read mux, no side effects.
    always_comb begin
        RData = '0;
        if (sel) begin
            case (idx)
                2'd0:    RData = {28'd0, ctrl_q};
                2'd1:    RData = preset_q;
                2'd2:    RData = count_q;
                default: RData = '0;
            endcase
        end
    end

    // Timer sequencing, then CPU writes layered on top so a bus write to CTRL
    // overrides the Enable clear from INT and any register write drops the flag.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    irq_d   = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                state_d = S_IDLE;
                if (ctrl_q[2:1] == 2'b01) begin
                    irq_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wr) begin
            case (idx)
                2'd0: begin
                    ctrl_d = WData[3:0];
                    irq_d  = 1'b0;
                end
                2'd1: begin
                    preset_d = WData;
                    irq_d    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // State and register update with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    assign IRQ = ctrl_q[3] & irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: expected COUNT/IRQ values are computed
// from the edge-timing rules (LOAD at e1, COUNT=N at e2, INT at e(N+2), period N+3).
module tb_timer_dev;

    localparam logic [31:0] A_CTRL = 32'h0000_7F00;
    localparam logic [31:0] A_PRE  = 32'h0000_7F04;
    localparam logic [31:0] A_CNT  = 32'h0000_7F08;
    localparam logic [31:0] A_RSV  = 32'h0000_7F0C;
    localparam logic [31:0] A_T1P  = 32'h0000_7F14;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [29:0] Addr = '0;
    logic [3:0]  WE = '0;
    logic [31:0] WData = '0;
    logic [31:0] RData;
    logic        IRQ;

    int n_cmp = 0;
    int n_err = 0;

    timer_dev #(.BASE(32'h0000_7F00)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .WData (WData),
        .RData (RData),
        .IRQ   (IRQ)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        WE = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    // Write lands on the next posedge; returns 1 time unit after it.
    task automatic bus_wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        @(negedge clk);
        Addr  = a[31:2];
        WE    = we;
        WData = d;
        tick();
        WE = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Addr = a[31:2];
        #1;
        d = RData;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] addrs [5];
        addrs = '{A_CTRL, A_PRE, A_CNT, A_RSV, 32'h0000_7F10};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rd(addrs[i], v);
            n_cmp++;
            if (v !== 32'd0) begin
                n_err++;
                $display("FAIL reset_read addr=%h got=%h exp=0", addrs[i], v);
            end
        end
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq got=%b exp=0", IRQ);
        end
    endtask

    task automatic test_ignored_writes();
        logic [31:0] v;
        logic [31:0] d;
        logic [31:0] c;
        do_reset();
        bus_wr(A_PRE, 4'hF, 32'h55);
        bus_wr(A_CNT, 4'hF, 32'h1234);
        bus_wr(A_PRE, 4'b0001, 32'hAAAA_AAAA);
        bus_wr(A_PRE, 4'b0011, 32'hBBBB_BBBB);
        bus_wr(A_RSV, 4'hF, 32'hFFFF_FFFF);
        bus_wr(A_T1P, 4'hF, 32'hDEAD_BEEF);
        bus_wr(A_CTRL, 4'b1110, 32'hF);
        rd(A_CTRL, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL ign_ctrl got=%h exp=0", v); end
        rd(A_PRE, v);
        n_cmp++;
        if (v !== 32'h55) begin n_err++; $display("FAIL ign_preset got=%h exp=55", v); end
        rd(A_CNT, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL ign_count got=%h exp=0", v); end
        rd(A_RSV, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL ign_rsv got=%h exp=0", v); end
        rd(A_T1P, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL ign_unsel got=%h exp=0", v); end
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            c = $urandom & 32'hFFFF_FFFE;
            bus_wr(A_PRE, 4'hF, d);
            bus_wr(A_CTRL, 4'hF, c);
            rd(A_PRE, v);
            n_cmp++;
            if (v !== d) begin n_err++; $display("FAIL rw_preset got=%h exp=%h", v, d); end
            rd(A_CTRL, v);
            n_cmp++;
            if (v !== {28'd0, c[3:0]}) begin
                n_err++;
                $display("FAIL rw_ctrl got=%h exp=%h", v, {28'd0, c[3:0]});
            end
        end
    endtask

    // One-shot modes (00, 10, 11): IRQ = IM once COUNT expires, Enable self-clears.
    task automatic test_oneshot();
        logic [31:0] v;
        int n, neff, m, ec;
        logic im, eirq;
        logic [1:0] mode;
        logic [3:0] ctrl;
        for (int it = 0; it < 5; it++) begin
            do_reset();
            n  = (it == 0) ? 5 : int'($urandom_range(0, 10));
            im = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            m  = (it == 0) ? 0 : int'($urandom_range(0, 2));
            mode = (m == 0) ? 2'b00 : 2'(m + 1);
            neff = (n == 0) ? 1 : n;
            ctrl = {im, mode, 1'b1};
            bus_wr(A_PRE, 4'hF, 32'(n));
            bus_wr(A_CTRL, 4'hF, {28'd0, ctrl});
            for (int k = 1; k <= neff + 4; k++) begin
                tick();
                rd(A_CNT, v);
                ec   = (k < 2 || (k - 2) >= n) ? 0 : n - (k - 2);
                eirq = im && (k >= neff + 2);
                n_cmp++;
                if (v !== 32'(ec)) begin
                    n_err++;
                    $display("FAIL os_count n=%0d k=%0d got=%0d exp=%0d", n, k, v, ec);
                end
                n_cmp++;
                if (IRQ !== eirq) begin
                    n_err++;
                    $display("FAIL os_irq n=%0d k=%0d got=%b exp=%b", n, k, IRQ, eirq);
                end
            end
            rd(A_CTRL, v);
            n_cmp++;
            if (v !== {28'd0, im, mode, 1'b0}) begin
                n_err++;
                $display("FAIL os_ctrl_en_clr got=%h exp=%h", v, {28'd0, im, mode, 1'b0});
            end
            bus_wr(A_CTRL, 4'hF, 32'h8);
            n_cmp++;
            if (IRQ !== 1'b0) begin
                n_err++;
                $display("FAIL os_irq_clear got=%b exp=0", IRQ);
            end
        end
    endtask

    // Mode 01: one-cycle pulses every N+3 cycles, COUNT reloaded to N.
    task automatic test_periodic();
        logic [31:0] v;
        int n, neff, per, p0, i, ec;
        logic eirq;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            n    = (it == 0) ? 3 : int'($urandom_range(0, 6));
            neff = (n == 0) ? 1 : n;
            per  = neff + 3;
            p0   = neff + 2;
            bus_wr(A_PRE, 4'hF, 32'(n));
            bus_wr(A_CTRL, 4'hF, 32'hB);
            for (int k = 1; k <= p0 + 3 * per; k++) begin
                tick();
                rd(A_CNT, v);
                i    = (k - 2) % per;
                ec   = (k < 2 || i >= n) ? 0 : n - i;
                eirq = (k >= p0) && (((k - p0) % per) == 0);
                n_cmp++;
                if (v !== 32'(ec)) begin
                    n_err++;
                    $display("FAIL per_count n=%0d k=%0d got=%0d exp=%0d", n, k, v, ec);
                end
                n_cmp++;
                if (IRQ !== eirq) begin
                    n_err++;
                    $display("FAIL per_irq n=%0d k=%0d got=%b exp=%b", n, k, IRQ, eirq);
                end
            end
        end
    endtask

    task automatic test_disable_midcount();
        logic [31:0] v;
        int ec;
        do_reset();
        bus_wr(A_PRE, 4'hF, 32'd8);
        bus_wr(A_CTRL, 4'hF, 32'h9);
        for (int k = 1; k <= 5; k++) tick();
        rd(A_CNT, v);
        n_cmp++;
        if (v !== 32'd5) begin n_err++; $display("FAIL dis_pre got=%0d exp=5", v); end
        // Disable lands on edge 6, which still decrements to 4; then frozen.
        bus_wr(A_CTRL, 4'hF, 32'h8);
        for (int k = 0; k < 5; k++) begin
            tick();
            rd(A_CNT, v);
            n_cmp++;
            if (v !== 32'd4) begin n_err++; $display("FAIL dis_freeze got=%0d exp=4", v); end
            n_cmp++;
            if (IRQ !== 1'b0) begin n_err++; $display("FAIL dis_irq got=%b exp=0", IRQ); end
        end
        // Re-enable reloads from PRESET; PRESET change mid-run waits for next LOAD.
        bus_wr(A_CTRL, 4'hF, 32'h9);
        tick();
        tick();
        rd(A_CNT, v);
        n_cmp++;
        if (v !== 32'd8) begin n_err++; $display("FAIL dis_reload got=%0d exp=8", v); end
        bus_wr(A_PRE, 4'hF, 32'd9);
        for (int k = 3; k <= 11; k++) begin
            if (k > 3) tick();
            rd(A_CNT, v);
            ec = ((k - 2) >= 8) ? 0 : 8 - (k - 2);
            n_cmp++;
            if (v !== 32'(ec)) begin
                n_err++;
                $display("FAIL mid_preset_count k=%0d got=%0d exp=%0d", k, v, ec);
            end
            n_cmp++;
            if (IRQ !== (k >= 10)) begin
                n_err++;
                $display("FAIL mid_preset_irq k=%0d got=%b exp=%b", k, IRQ, (k >= 10));
            end
        end
        bus_wr(A_CTRL, 4'hF, 32'h9);
        tick();
        tick();
        rd(A_CNT, v);
        n_cmp++;
        if (v !== 32'd9) begin n_err++; $display("FAIL next_run_start got=%0d exp=9", v); end
        tick();
        rd(A_CNT, v);
        n_cmp++;
        if (v !== 32'd8) begin n_err++; $display("FAIL next_run_dec got=%0d exp=8", v); end
    endtask

    task automatic test_im_masked();
        logic [31:0] v;
        do_reset();
        bus_wr(A_PRE, 4'hF, 32'd2);
        bus_wr(A_CTRL, 4'hF, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_cmp++;
            if (IRQ !== 1'b0) begin n_err++; $display("FAIL mask_irq k=%0d got=%b exp=0", k, IRQ); end
        end
        rd(A_CNT, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL mask_count got=%0d exp=0", v); end
        bus_wr(A_CTRL, 4'hF, 32'h8);
        n_cmp++;
        if (IRQ !== 1'b0) begin n_err++; $display("FAIL mask_unmask got=%b exp=0", IRQ); end
        tick();
        n_cmp++;
        if (IRQ !== 1'b0) begin n_err++; $display("FAIL mask_unmask2 got=%b exp=0", IRQ); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] v;
        do_reset();
        bus_wr(A_PRE, 4'hF, 32'd10);
        bus_wr(A_CTRL, 4'hF, 32'h9);
        for (int k = 1; k <= 7; k++) tick();
        rd(A_CNT, v);
        n_cmp++;
        if (v !== 32'd5) begin n_err++; $display("FAIL rmid_pre got=%0d exp=5", v); end
        #1;
        reset = 1'b1;
        rd(A_CNT, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL rmid_async_count got=%0d exp=0", v); end
        rd(A_CTRL, v);
        n_cmp++;
        if (v !== 32'd0) begin n_err++; $display("FAIL rmid_async_ctrl got=%h exp=0", v); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            rd(A_CNT, v);
            n_cmp++;
            if (v !== 32'd0) begin n_err++; $display("FAIL rmid_idle got=%0d exp=0", v); end
        end
        n_cmp++;
        if (IRQ !== 1'b0) begin n_err++; $display("FAIL rmid_irq got=%b exp=0", IRQ); end
    endtask

    initial begin
        test_reset();
        test_ignored_writes();
        test_oneshot();
        test_periodic();
        test_disable_midcount();
        test_im_masked();
        test_reset_midcount();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
